uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 108, means i_clk cycles per UART bit (100 MHz / 921600 baud, truncated).
REQ-002 Parameter FIFO_DEPTH, default 16, means the byte FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 i_clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_data  input  8  byte to transmit.
REQ-006 i_valid  input  1  i_data is valid this cycle.
REQ-007 o_ready  output  1  FIFO can accept a byte; equals not-full.
REQ-008 o_tx  output  1  serial line, idle high; drives the SoC o_uart_rx pin.
REQ-009 o_busy  output  1  serializer not IDLE, or FIFO not empty.
REQ-010 o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, excluding the byte in the shifter.

Function
REQ-011 A push SHALL occur on each rising edge where i_valid and o_ready are both 1; i_data is ignored otherwise.
REQ-012 o_ready SHALL be 0 when o_level == FIFO_DEPTH; a push attempt while full SHALL be dropped with no state change.
REQ-013 Serializer FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: o_tx=1; if FIFO non-empty, pop the head byte into the shift register and go to START on the same edge.
REQ-015 START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-016 DATA: o_tx=shift[0], LSB first, CLKS_PER_BIT cycles per bit; after bit 7, go to STOP.
REQ-017 STOP: o_tx=1 for CLKS_PER_BIT cycles; on the final STOP cycle, if FIFO non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-018 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL be contiguous.
REQ-019 Latency: a byte pushed at edge N into an empty FIFO with FSM IDLE is popped at edge N+1, and o_tx=0 from edge N+1.
REQ-020 A simultaneous push and pop SHALL leave o_level unchanged and preserve FIFO order.
REQ-021 The bit counter (0..CLKS_PER_BIT-1) and the FIFO pointers SHALL wrap modulo their range; pointer width is $clog2(FIFO_DEPTH), with a separate occupancy count.
REQ-022 o_tx SHALL be registered (glitch-free).

Reset
REQ-023 While i_rst=1 at an edge: FSM=IDLE, o_tx=1, FIFO emptied, o_level=0, o_ready=1, o_busy=0, and the counters cleared.
REQ-024 A reset mid-frame SHALL abort the frame, with o_tx=1 from the next edge; queued bytes are discarded.
REQ-025 Pushes in a cycle with i_rst=1 SHALL be ignored.

Structure
REQ-026 Package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP), the default CLKS_PER_BIT constant, and the default FIFO_DEPTH constant.
REQ-027 The FIFO SHALL be a sub-module named sync_fifo (parameterised width and depth, with push/pop/full/empty/level); the serializer FSM is in uart_tx_fifo.

Verification
REQ-028 Single byte: push 0x55 from idle -> o_tx low for 108 cycles, then bits 1,0,1,0,1,0,1,0 for 108 cycles each, then high for 108 cycles; o_busy falls after 1080 cycles.
REQ-029 Back-to-back: push 0x41, 0x42, 0x43 on consecutive cycles -> three contiguous 1080-cycle frames with no idle cycle between them; the bench UART receiver prints 'A', 'B', 'C'.
REQ-030 Full: push 17 bytes on consecutive edges from idle -> o_level=16 and o_ready=0 after the 17th push; an 18th push is dropped; o_ready returns to 1 on the edge popping byte 2 (frame 1 end).
REQ-031 Simultaneous: push on the same edge as the final STOP-cycle pop with level 3 -> level stays 3; the output order is unchanged.
REQ-032 Reset mid-frame: assert i_rst for 1 cycle during DATA bit 4 of 0x00 with 5 queued -> o_tx=1 next edge, o_level=0, o_busy=0, and no further frames.
REQ-033 Parameter sweep: CLKS_PER_BIT=4, FIFO_DEPTH=2 -> 40-cycle frames; o_ready=0 after 3 back-to-back pushes.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
// Serializer states and default timing/depth constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    // 100 MHz / 921600 baud, truncated
    localparam int CLKS_PER_BIT_DEF = 108;
    localparam int FIFO_DEPTH_DEF   = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter.
// Producer drives data/valid, transmitter returns ready.
interface uart_tx_fifo_if;

    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;

    modport master (
        output i_data,
        output i_valid,
        input  o_ready
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth.
// Wrapping pointers plus a separate occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == LW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = count_q;

    // Pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + LW'(do_push) - LW'(do_pop);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; a stale write during reset is harmless
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO.
// Back-to-back frames are contiguous; o_tx is registered.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    uart_tx_fifo_if.slave               bus,
    output logic                        o_tx,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int CW =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;

    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        bit_done;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (bus.i_valid),
        .pop   (fifo_pop),
        .din   (bus.i_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_level)
    );

    assign bus.o_ready = !fifo_full;
    assign o_busy      = (state_q != IDLE) || !fifo_empty;
    assign o_tx        = tx_q;
    assign bit_done    = (cnt_q == CNT_LAST);

    // Next state: pop on idle or on the last stop cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state being entered, so it is registered
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Serializer state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: two instances (default and 4/2 params).
// A queue-and-timestamp line model and a UART receiver check both.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int CA = 108;
    localparam int DA = 16;
    localparam int CB = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       chk_en;
    logic       tx_a, busy_a, tx_b, busy_b;
    logic [4:0] level_a;
    logic [1:0] level_b;
    logic       tx_sel, busy_sel;
    int         C, D;

    uart_tx_fifo_if bus_a ();
    uart_tx_fifo_if bus_b ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CA),
        .FIFO_DEPTH   (DA)
    ) dut_a (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus_a),
        .o_tx    (tx_a),
        .o_busy  (busy_a),
        .o_level (level_a)
    );

    uart_tx_fifo #(
        .CLKS_PER_BIT (CB),
        .FIFO_DEPTH   (DB)
    ) dut_b (
        .i_clk   (clk),
        .i_rst   (rst),
        .bus     (bus_b),
        .o_tx    (tx_b),
        .o_busy  (busy_b),
        .o_level (level_b)
    );

    assign tx_sel   = sel ? tx_b : tx_a;
    assign busy_sel = sel ? busy_b : busy_a;
    always_comb C = sel ? CB : CA;
    always_comb D = sel ? DB : DA;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, current frame byte and its start cycle
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] rx[$];
    logic       m_act = 1'b0;
    logic [7:0] m_cur = 8'h00;
    longint     m_t0  = 0;
    longint     cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            if (errors <= 40)
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d,
                              input logic r);
        int     sz;
        longint e;
        cyc++;
        if (r) begin
            mq.delete();
            m_act = 1'b0;
            return;
        end
        sz = mq.size();
        e  = cyc - m_t0;
        if (m_act && e == longint'(10 * C)) m_act = 1'b0;
        if (!m_act && sz > 0) begin
            m_cur = mq.pop_front();
            m_act = 1'b1;
            m_t0  = cyc;
            sent.push_back(m_cur);
        end
        if (v && sz < D) mq.push_back(d);
    endtask

    // Frame = 1 start bit, 8 data bits LSB first, 1 stop bit, C cycles each
    function automatic logic exp_tx();
        longint e;
        if (!m_act) return 1'b1;
        e = cyc - m_t0;
        if (e < C) return 1'b0;
        if (e < 9 * C) return m_cur[int'((e - C) / C)];
        return 1'b1;
    endfunction

    task automatic cycle_checks();
        check("tx", {31'b0, tx_sel}, {31'b0, exp_tx()});
        check("level", sel ? 32'(level_b) : 32'(level_a), mq.size());
        check("ready", sel ? bus_b.o_ready : bus_a.o_ready,
              {31'b0, mq.size() < D});
        check("busy", {31'b0, busy_sel},
              {31'b0, (m_act || mq.size() > 0)});
        check("other_tx", sel ? tx_a : tx_b, 1);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        rst = r;
        bus_a.i_valid = sel ? 1'b0 : v;
        bus_a.i_data  = d;
        bus_b.i_valid = sel ? v : 1'b0;
        bus_b.i_data  = d;
        @(posedge clk);
        model_edge(v, d, r);
        @(negedge clk);
        if (chk_en) cycle_checks();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy_sel && n < max) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        check("drain_timeout", {31'b0, n < max}, 1);
    endtask

    task automatic count_busy(input string tag, input int exp);
        int n = 0;
        while (busy_sel && n < 5000) begin
            n++;
            step(1'b0, 8'h00, 1'b0);
        end
        check(tag, n, exp);
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx.size()) return rx[i];
        return 8'hxx;
    endfunction

    task automatic check_rx();
        check("rx_count", rx.size(), sent.size());
        for (int i = 0; i < sent.size(); i++)
            check("rx_byte", {24'b0, rx_at(i)}, {24'b0, sent[i]});
    endtask

    task automatic clear_logs();
        rx.delete();
        sent.delete();
    endtask

    // Bench UART receiver: samples mid-bit on the selected line
    initial begin : rx_proc
        logic [7:0] b;
        int c;
        forever begin
            @(negedge clk);
            if (tx_sel === 1'b0) begin
                c = C;
                repeat (c / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (c) @(negedge clk);
                    b[i] = tx_sel;
                end
                repeat (c) @(negedge clk);
                rx.push_back(b);
                $display("rx byte 0x%02h '%c'", b, b);
            end
        end
    end

    initial begin : stim
        logic [7:0] fd[17];
        logic [7:0] sd[5];
        int n;

        rst = 1'b1;
        sel = 1'b0;
        chk_en = 1'b0;
        bus_a.i_valid = 1'b0;
        bus_a.i_data  = 8'h00;
        bus_b.i_valid = 1'b0;
        bus_b.i_data  = 8'h00;
        repeat (3) step(1'b0, 8'h00, 1'b1);
        check("rst_tx_a", tx_a, 1);
        check("rst_tx_b", tx_b, 1);
        check("rst_level_a", 32'(level_a), 0);
        check("rst_level_b", 32'(level_b), 0);
        check("rst_ready_a", bus_a.o_ready, 1);
        check("rst_ready_b", bus_b.o_ready, 1);
        check("rst_busy_a", busy_a, 0);
        check("rst_busy_b", busy_b, 0);
        chk_en = 1'b1;

        // Single byte 0x55 from idle
        step(1'b1, 8'h55, 1'b0);
        count_busy("busy_len_55", 1081);
        idle(5);
        check("rx_55_count", rx.size(), 1);
        check("rx_55", {24'b0, rx_at(0)}, 32'h55);
        clear_logs();

        // Back-to-back A, B, C
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        step(1'b1, 8'h43, 1'b0);
        count_busy("busy_len_abc", 3239);
        idle(5);
        check("rx_abc_count", rx.size(), 3);
        check("rx_A", {24'b0, rx_at(0)}, 32'h41);
        check("rx_B", {24'b0, rx_at(1)}, 32'h42);
        check("rx_C", {24'b0, rx_at(2)}, 32'h43);
        clear_logs();

        // Fill: 17 pushes, 18th dropped, ready back at frame 1 end
        foreach (fd[i]) fd[i] = 8'($urandom);
        foreach (fd[i]) step(1'b1, fd[i], 1'b0);
        check("full_level", 32'(level_a), 16);
        check("full_ready", bus_a.o_ready, 0);
        step(1'b1, 8'hEE, 1'b0);
        check("drop_level", 32'(level_a), 16);
        n = 0;
        while (!bus_a.o_ready && n < 2000) begin
            step(1'b0, 8'h00, 1'b0);
            n++;
        end
        check("ready_return", n, 1064);
        check("after_pop_level", 32'(level_a), 15);
        check("full_rx0", {24'b0, rx_at(0)}, {24'b0, fd[0]});
        step(1'b0, 8'h00, 1'b1);
        idle(1200);
        clear_logs();

        // Push coinciding with the final-stop pop at level 3
        foreach (sd[i]) sd[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) step(1'b1, sd[i], 1'b0);
        check("sim_level_pre", 32'(level_a), 3);
        idle(1077);
        check("sim_level_edge", 32'(level_a), 3);
        step(1'b1, sd[4], 1'b0);
        check("sim_level_post", 32'(level_a), 3);
        check("sim_restart_tx", tx_a, 0);
        wait_idle(6000);
        idle(5);
        check("sim_rx_count", rx.size(), 5);
        foreach (sd[i])
            check("sim_order", {24'b0, rx_at(i)}, {24'b0, sd[i]});
        clear_logs();

        // Reset during data bit 4 of 0x00 with 5 bytes queued
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        check("rstmid_level", 32'(level_a), 5);
        idle(555);
        check("rstmid_bit4", tx_a, 0);
        step(1'b0, 8'h00, 1'b1);
        check("rstmid_tx", tx_a, 1);
        check("rstmid_level0", 32'(level_a), 0);
        check("rstmid_busy", busy_a, 0);
        check("rstmid_ready", bus_a.o_ready, 1);
        idle(1500);
        clear_logs();

        // Sparse random traffic on the default instance
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 399) == 0, 8'($urandom), 1'b0);
        wait_idle(20000);
        idle(5);
        check_rx();
        clear_logs();

        // Small instance: 4 clocks per bit, depth 2
        sel = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        clear_logs();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        check("small_ready", bus_b.o_ready, 0);
        check("small_level", 32'(level_b), 2);
        count_busy("small_busy_len", 119);
        idle(5);
        check_rx();
        clear_logs();

        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) == 0, 8'($urandom), 1'b0);
        wait_idle(1000);
        idle(5);
        check_rx();
        clear_logs();

        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 299) == 0);
        wait_idle(1000);
        idle(50);
        clear_logs();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
